// File: rtl/muldiv_ctrl.sv
// Sequencer between Execute and the iterative mul/div engines: accepts one request, starts the engine, sign-corrects {hi,lo}.
// Latency: engine latency + 2 cycles (divide-by-zero answers the cycle after accept); response waits on resp_ready; flush aborts.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  input  logic        resp_ready,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_c,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [63:0] div_c
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t      state;
  logic        divOp;
  logic        signA;
  logic        signB;
  logic [31:0] magA;
  logic [31:0] magB;

  logic        reqSignA;
  logic        reqSignB;
  logic [31:0] reqMagA;
  logic [31:0] reqMagB;
  logic        engDone;
  logic [63:0] prodFix;
  logic [31:0] quoFix;
  logic [31:0] remFix;
  logic [31:0] fixHi;
  logic [31:0] fixLo;

  // Only signed ops (op[0]==0) carry a sign; 0x8000_0000 negates to itself.
  always_comb begin
    reqSignA = ~req_op[0] & req_a[31];
    reqSignB = ~req_op[0] & req_b[31];
    reqMagA  = reqSignA ? (~req_a + 32'd1) : req_a;
    reqMagB  = reqSignB ? (~req_b + 32'd1) : req_b;
  end

  always_comb begin
    engDone = divOp ? div_done : mul_done;
    prodFix = (signA ^ signB) ? (~mul_c + 64'd1) : mul_c;
    quoFix  = (signA ^ signB) ? (~div_c[31:0] + 32'd1) : div_c[31:0];
    remFix  = signA ? (~div_c[63:32] + 32'd1) : div_c[63:32];
    fixHi   = divOp ? remFix : prodFix[63:32];
    fixLo   = divOp ? quoFix : prodFix[31:0];
  end

  assign mul_a = magA;
  assign mul_b = magB;
  assign div_a = magA;
  assign div_b = magB;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      divOp      <= 1'b0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      magA       <= '0;
      magB       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hi    <= '0;
      resp_lo    <= '0;
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
    end else if (flush) begin
      // Flush wins over a same-cycle done or handoff.
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      mul_start  <= 1'b0;
      div_start  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            divOp     <= req_op[1];
            signA     <= reqSignA;
            signB     <= reqSignB;
            magA      <= reqMagA;
            magB      <= reqMagB;
            req_ready <= 1'b0;
            if (req_op[1] && (req_b == 32'd0)) begin
              resp_hi    <= req_a;
              resp_lo    <= 32'hFFFF_FFFF;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              mul_start <= ~req_op[1];
              div_start <= req_op[1];
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (engDone) begin
            resp_hi    <= fixHi;
            resp_lo    <= fixLo;
            resp_valid <= 1'b1;
            mul_start  <= 1'b0;
            div_start  <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural engines plus an arithmetic reference for signed/unsigned mul/div results.
module tb_muldiv_ctrl;
  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_ready;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_c;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done;
  logic [63:0] div_c;

  int total = 0;
  int bad = 0;

  muldiv_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .flush(flush),
    .resp_valid(resp_valid), .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_ready(resp_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_c(div_c)
  );

  always #5 clk = ~clk;

  // Expected {hi,lo} straight from signed/unsigned arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: t = sa * sb;
      2'd1: t = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) t = {a, 32'hFFFF_FFFF};
        else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          t = {32'(r), 32'(q)};
        end else t = {a % b, a / b};
      end
    endcase
    return t;
  endfunction

  function automatic logic [31:0] ref_mag(input logic [1:0] op, input logic [31:0] x);
    longint s;
    s = op[0] ? longint'({32'b0, x}) : longint'($signed(x));
    if (s < 0) s = -s;
    return 32'(s);
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int hold);
    logic [63:0] expRes;
    logic [31:0] expMa, expMb;
    logic        isDiv, dz;
    expRes = ref_result(op, a, b);
    expMa  = ref_mag(op, a);
    expMb  = ref_mag(op, b);
    isDiv  = op[1];
    dz     = isDiv && (b == 32'd0);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_before_req: got %b want 1", req_ready); end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
    if (dz) begin
      total++; if (resp_valid !== 1'b1 || mul_start !== 1'b0 || div_start !== 1'b0) begin
        bad++; $display("FAIL divzero_accept: got valid=%b ms=%b ds=%b want 1 0 0", resp_valid, mul_start, div_start);
      end
    end else begin
      total++; if ({mul_start, div_start} !== (isDiv ? 2'b01 : 2'b10) || resp_valid !== 1'b0) begin
        bad++; $display("FAIL start_after_accept: got ms=%b ds=%b valid=%b op=%0d", mul_start, div_start, resp_valid, op);
      end
      total++; if ((isDiv ? div_a : mul_a) !== expMa || (isDiv ? div_b : mul_b) !== expMb) begin
        bad++; $display("FAIL operand_mag: got %h/%h want %h/%h", isDiv ? div_a : mul_a, isDiv ? div_b : mul_b, expMa, expMb);
      end
      for (int i = 1; i < lat; i++) begin
        if (isDiv) begin mul_done = 1'b1; mul_c = {$urandom, $urandom}; end
        else begin div_done = 1'b1; div_c = {$urandom, $urandom}; end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || (isDiv ? div_start : mul_start) !== 1'b1 ||
                     (isDiv ? div_a : mul_a) !== expMa || (isDiv ? div_b : mul_b) !== expMb) begin
          bad++; $display("FAIL run_hold: got valid=%b a=%h b=%h want 0 %h %h", resp_valid, isDiv ? div_a : mul_a, isDiv ? div_b : mul_b, expMa, expMb);
        end
      end
      mul_done = 1'b0; div_done = 1'b0;
      if (isDiv) begin div_done = 1'b1; div_c = {div_a % div_b, div_a / div_b}; end
      else begin mul_done = 1'b1; mul_c = {32'b0, mul_a} * {32'b0, mul_b}; end
      @(negedge clk);
      mul_done = 1'b0; div_done = 1'b0;
      total++; if (resp_valid !== 1'b1 || mul_start !== 1'b0 || div_start !== 1'b0) begin
        bad++; $display("FAIL resp_after_done: got valid=%b ms=%b ds=%b want 1 0 0", resp_valid, mul_start, div_start);
      end
    end
    total++; if ({resp_hi, resp_lo} !== expRes) begin
      bad++; $display("FAIL result op=%0d a=%h b=%h: got %h_%h want %h", op, a, b, resp_hi, resp_lo, expRes);
    end
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || {resp_hi, resp_lo} !== expRes) begin
        bad++; $display("FAIL resp_stall: got valid=%b ready=%b %h_%h want 1 0 %h", resp_valid, req_ready, resp_hi, resp_lo, expRes);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || {resp_hi, resp_lo} !== expRes) begin
      bad++; $display("FAIL handoff: got valid=%b ready=%b %h_%h want 0 1 %h", resp_valid, req_ready, resp_hi, resp_lo, expRes);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mul_start !== 1'b0 || div_start !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: got rdy=%b valid=%b ms=%b ds=%b want 1 0 0 0", req_ready, resp_valid, mul_start, div_start);
    end
    total++; if ({resp_hi, resp_lo, mul_a, mul_b, div_a, div_b} !== 192'd0) begin
      bad++; $display("FAIL reset_data: got %h %h %h %h want zeros", resp_hi, resp_lo, mul_a, mul_b);
    end
    resetn = 1'b1;
  endtask

  task automatic test_plan_vectors();
    do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 4, 0);
    do_op(2'd3, 32'd100, 32'd7, 3, 0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 2, 0);
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 3, 0);
    do_op(2'd2, 32'd5, 32'd0, 1, 0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 5);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1);
    do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 2, 0);
  endtask

  task automatic test_flush();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd5; req_b = 32'd6;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mul_done = 1'b1; mul_c = 64'd30;
    total++; if (mul_start !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL flush_run: got ms=%b valid=%b rdy=%b want 0 0 1", mul_start, resp_valid, req_ready);
    end
    @(negedge clk);
    mul_done = 1'b0;
    total++; if (mul_start !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL flush_late_done: got ms=%b valid=%b rdy=%b want 0 0 1", mul_start, resp_valid, req_ready);
    end
    do_op(2'd1, 32'd3, 32'd4, 3, 0);
    // done and flush in the same cycle: result must be dropped
    req_valid = 1'b1; req_op = 2'd3; req_a = 32'd50; req_b = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    div_done = 1'b1; div_c = {32'd2, 32'd16}; flush = 1'b1;
    @(negedge clk);
    div_done = 1'b0; flush = 1'b0;
    total++; if (resp_valid !== 1'b0 || div_start !== 1'b0 || req_ready !== 1'b1 || {resp_hi, resp_lo} !== 64'd12) begin
      bad++; $display("FAIL flush_with_done: got valid=%b ds=%b rdy=%b %h_%h want 0 0 1 0_c", resp_valid, div_start, req_ready, resp_hi, resp_lo);
    end
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd9; req_b = 32'd9; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    total++; if (req_ready !== 1'b1 || mul_start !== 1'b0 || div_start !== 1'b0) begin
      bad++; $display("FAIL flush_idle: got rdy=%b ms=%b ds=%b want 1 0 0", req_ready, mul_start, div_start);
    end
    req_valid = 1'b1; req_op = 2'd3; req_a = 32'd8; req_b = 32'd0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL flush_resp: got valid=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd11; req_b = 32'd13;
    @(negedge clk);
    req_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    total++; if (mul_start !== 1'b0 || req_ready !== 1'b1 || mul_a !== 32'd0 || resp_hi !== 32'd0 || resp_lo !== 32'd0) begin
      bad++; $display("FAIL async_reset: got ms=%b rdy=%b a=%h lo=%h want 0 1 0 0", mul_start, req_ready, mul_a, resp_lo);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(op, a, b, $urandom_range(1, 6), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) do_op(2'(n), 32'($urandom_range(0, 1000)) - 32'd500, 32'($urandom_range(1, 50)), 1, 0);
  endtask

  initial begin
    clk = 1'b0; resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0;
    flush = 1'b0; resp_ready = 1'b0; mul_done = 1'b0; mul_c = '0; div_done = 1'b0; div_c = '0;
    test_reset();
    test_plan_vectors();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer that sits between the Execute stage and the shared iterative multiplier/divider engines. It accepts one MULT/MULTU/DIV/DIVU request at a time and converts signed operands to magnitudes. It holds the selected engine's start level until the engine reports done, applies sign correction to the 64-bit result, and presents {hi, lo} through a valid/ready response port. A pipeline flush aborts any operation in flight.

## Interface
Parameters: none.

- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  Execute presents a request
- req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- req_a  in  32  rs operand (multiplicand / dividend)
- req_b  in  32  rt operand (multiplier / divisor)
- req_ready  out  1  controller can accept a request (state IDLE)
- flush  in  1  exception/redirect; abort current operation
- resp_valid  out  1  hi/lo result available
- resp_hi  out  32  HI result
- resp_lo  out  32  LO result
- resp_ready  in  1  consumer takes result
- mul_start  out  1  level start to multiplier engine
- mul_a, mul_b  out  32 each  unsigned magnitudes to multiplier
- mul_done  in  1  multiplier result valid (one or more cycles)
- mul_c  in  64  unsigned product
- div_start  out  1  level start to divider engine
- div_a, div_b  out  32 each  unsigned magnitudes to divider
- div_done  in  1  divider result valid
- div_c  in  64  {remainder[63:32], quotient[31:0]}, unsigned

## Operation
- States: IDLE, RUN, RESP.
- IDLE: req_ready=1. On req_valid && !flush:
  - Latch op, the sign of a, the sign of b, and the magnitudes.
  - Magnitude rule: signed ops with operand[31]=1 use (~x+1) as unsigned 32-bit, so 0x8000_0000 maps to 0x8000_0000. Unsigned ops pass operands unchanged.
  - Normally go to RUN.
- Divide by zero (DIV/DIVU, req_b==0): engine not started. Go directly to RESP with hi=req_a, lo=0xFFFF_FFFF.
- RUN:
  - mul_start or div_start (per op) held at 1; the other start stays 0.
  - Engine operand outputs are driven from latched magnitudes and stay stable for the whole of RUN.
  - The done input of the non-selected engine is ignored.
  - On the selected done: latch the corrected result, drop start, and go to RESP.
- Sign correction:
  - MULT: 64-bit product negated (two's complement) when sign_a != sign_b.
  - DIV: quotient negated when sign_a != sign_b; remainder negated when sign_a=1.
  - Unsigned ops: raw engine result.
  - hi = product[63:32] / remainder; lo = product[31:0] / quotient.
- RESP: resp_valid=1 with stable hi/lo. On resp_ready, go to IDLE. Not ready while in RESP; no new request accepted until back in IDLE.
- flush (any state):
  - Next state IDLE; starts and resp_valid drop on the next edge.
  - A done arriving in the same cycle as flush is discarded.
  - flush in IDLE blocks acceptance that cycle.
- resp_hi/resp_lo hold their last value outside RESP.

## Timing
- Reset (async assert): state IDLE, req_ready=1, resp_valid=0, mul_start=0, div_start=0, resp_hi=0, resp_lo=0, and all operand outputs 0.
- Accept at edge N (req_valid && req_ready high before N). The start output goes high after N.
- If the selected done is sampled high at edge M:
  - resp_valid goes high after M and start goes low after M.
  - Controller overhead is 2 cycles beyond engine latency.
- Divide by zero: resp_valid high the cycle after acceptance.
- Result handoff occurs at the edge where resp_valid && resp_ready. req_ready goes high the following cycle.
- Back-to-back throughput: at most one operation per (engine latency + 3) cycles.
- Reset deasserted mid-operation has no effect; reset asserted mid-operation returns to IDLE immediately (async).

## Test plan
- MULT a=0xFFFF_FFFE (-2), b=3, engine done after 4 cycles with mul_c=6 -> resp hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; resp_valid 1 cycle after done.
- DIVU a=100, b=7, div_c={2,14} -> hi=2, lo=14. DIV a=-7 (0xFFFF_FFF9), b=2, engine sees 7/2 -> hi=0xFFFF_FFFF (-1), lo=0xFFFF_FFFD (-3).
- MULT a=0x8000_0000, b=0x8000_0000 -> mul_a=mul_b=0x8000_0000; with mul_c=0x4000_0000_0000_0000 the response is hi=0x4000_0000, lo=0.
- DIV a=5, b=0 -> div_start never asserts; resp_valid next cycle with hi=5, lo=0xFFFF_FFFF.
- flush asserted 2 cycles into RUN, then done pulsed the following cycle -> start drops, no resp_valid, req_ready=1. A new MULTU 3×4 then completes with lo=12.
- resp_ready held low for 5 cycles in RESP -> hi/lo stable, req_ready=0, req_valid ignored. resp_ready=1 -> IDLE on the next cycle.
